// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_timer_pkg                                                             |
// | Register offsets and bit positions for the MMIO timer / TX-FIFO port.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mmio_timer_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_LOAD   = 5'h04;
  localparam logic [4:0] OFF_COUNT  = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_TXDATA = 5'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_EXPIRED = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_TXOVF   = 3;
  localparam int STAT_CNT_LSB = 4;

endpackage
`default_nettype wire

// File: rtl/io_byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_byte_fifo                                                               |
// | Byte FIFO with first-word-fall-through head; push accepted when full only  |
// | if a pop happens in the same cycle.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module io_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head  = mem_q[rd_ptr_q];
  assign valid = !empty;
  assign count = count_q;

  // Storage holds no meaningful state while empty, so it is left unreset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmio_timer_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_timer_port                                                            |
// | 32-byte MMIO window: down-counter timer with sticky expiry / irq, and a    |
// | byte transmit FIFO drained over valid/ready.                               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmio_timer_port
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]       ctrl_q,    ctrl_d;
  logic [CNT_W-1:0] load_q,    load_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic             expired_q, expired_d;
  logic             txovf_q,   txovf_d;
  logic [31:0]      rdata_q,   rdata_d;

  logic          sel_ok;
  logic [4:0]    off;
  logic          wr_ctrl, wr_load, wr_status, wr_tx;
  logic          timer_expire;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          ovf_evt;
  logic [31:0]   status_word;

  assign hit    = (addr[31:5] == BASE_ADDR[31:5]);
  assign sel_ok = hit && (addr[1:0] == 2'b00);
  assign off    = addr[4:0];

  assign wr_ctrl   = wr && sel_ok && (off == OFF_CTRL);
  assign wr_load   = wr && sel_ok && (off == OFF_LOAD);
  assign wr_status = wr && sel_ok && (off == OFF_STATUS);
  assign wr_tx     = wr && sel_ok && (off == OFF_TXDATA);

  assign fifo_pop = tx_valid && tx_ready;
  assign ovf_evt  = wr_tx && fifo_full && !fifo_pop;

  io_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (wdata[7:0]),
    .pop       (fifo_pop),
    .head      (tx_data),
    .valid     (tx_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Expiry is the 1 -> 0 step of a running counter; COUNT==0 while enabled is idle.
  assign timer_expire = ctrl_q[CTRL_EN] && (count_q == CNT_W'(1));

  always_comb begin
    status_word                        = '0;
    status_word[STAT_EXPIRED]          = expired_q;
    status_word[STAT_FULL]             = fifo_full;
    status_word[STAT_EMPTY]            = fifo_empty;
    status_word[STAT_TXOVF]            = txovf_q;
    status_word[STAT_CNT_LSB +: CW]    = fifo_count;
  end

  always_comb begin
    rdata_d = '0;
    if (sel_ok) begin
      case (off)
        OFF_CTRL:   rdata_d = {29'b0, ctrl_q};
        OFF_LOAD:   rdata_d = 32'(load_q);
        OFF_COUNT:  rdata_d = 32'(count_q);
        OFF_STATUS: rdata_d = status_word;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    expired_d = expired_q;
    txovf_d   = txovf_q;

    if (ctrl_q[CTRL_EN] && (count_q != '0)) begin
      if (timer_expire) begin
        if (ctrl_q[CTRL_AUTO]) begin
          count_d = load_q;
        end else begin
          count_d         = '0;
          ctrl_d[CTRL_EN] = 1'b0;
        end
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end

    if (wr_ctrl) begin
      ctrl_d = wdata[2:0];
      if (wdata[CTRL_EN] && !ctrl_q[CTRL_EN] && (count_q == '0)) begin
        count_d = load_q;
      end
    end

    // Bus writes to LOAD override whatever the timer step computed.
    if (wr_load) begin
      load_d  = wdata[CNT_W-1:0];
      count_d = wdata[CNT_W-1:0];
    end

    // Sticky bits: a hardware set beats a W1C in the same cycle.
    if (wr_status && wdata[STAT_EXPIRED]) expired_d = 1'b0;
    if (timer_expire)                     expired_d = 1'b1;
    if (wr_status && wdata[STAT_TXOVF])   txovf_d   = 1'b0;
    if (ovf_evt)                          txovf_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
      txovf_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      txovf_q   <= txovf_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = expired_q && ctrl_q[CTRL_IRQ_EN];

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mmio_timer_port                                                         |
// | Scoreboard bench: stimulus queues expectations, a monitor compares them.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mmio_timer_port;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_LOAD   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_TX     = BASE + 32'h10;

  localparam int K_RD  = 0;
  localparam int K_HIT = 1;
  localparam int K_IRQ = 2;
  localparam int K_TXV = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic        hit;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        irq;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        done = 1'b0;
  item_t       q[$];
  logic [7:0]  txq[$];

  mmio_timer_port #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4),
    .CNT_W      (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wr       (wr),
    .wdata    (wdata),
    .hit      (hit),
    .rdata    (rdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic rdy);
    @(posedge clk);
    #1;
    addr = a; wr = w; wdata = d; tx_ready = rdy;
  endtask

  task automatic exp_rd(input logic [31:0] v, input string n);
    q.push_back('{cyc + 1, K_RD, v, n});
  endtask

  task automatic exp_now(input int k, input logic [31:0] v, input string n);
    q.push_back('{cyc, k, v, n});
  endtask

  task automatic push_byte(input logic [7:0] b, input logic accept, input logic rdy);
    bus(A_TX, 1'b1, {24'h0, b}, rdy);
    if (accept) txq.push_back(b);
  endtask

  // Monitor: compares queued expectations and the TX stream at each falling edge.
  initial begin
    int          idx;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      idx = 0;
      while (idx < q.size()) begin
        if (q[idx].cyc <= cyc) begin
          case (q[idx].kind)
            K_RD:    act = rdata;
            K_HIT:   act = {31'b0, hit};
            K_IRQ:   act = {31'b0, irq};
            default: act = {31'b0, tx_valid};
          endcase
          checks++;
          if (q[idx].cyc != cyc || act !== q[idx].exp) begin
            errors++;
            $display("FAIL %s (cyc %0d): got %h expected %h", q[idx].name, cyc, act, q[idx].exp);
          end
          q.delete(idx);
        end else begin
          idx++;
        end
      end
      if (tx_valid === 1'b1) begin
        checks++;
        if (txq.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got %h expected no data", tx_data);
        end else begin
          if (tx_data !== txq[0]) begin
            errors++;
            $display("FAIL tx_head: got %h expected %h", tx_data, txq[0]);
          end
          if (tx_ready) void'(txq.pop_front());
        end
      end
      if (done) begin
        checks++;
        if (q.size() != 0 || txq.size() != 0) begin
          errors++;
          $display("FAIL leftover: got %0d/%0d pending expected 0/0", q.size(), txq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; addr = A_STATUS; wr = 1'b0;
    exp_now(K_RD, 32'h0, "rst_rdata");
    exp_now(K_TXV, 32'h0, "rst_txv");
    exp_now(K_IRQ, 32'h0, "rst_irq");
    exp_rd(32'h4, "rst_status");

    // One-shot timer with interrupt enabled
    bus(A_LOAD, 1'b1, 32'd3, 1'b0);
    bus(A_CTRL, 1'b1, 32'h5, 1'b0);
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd3, "os_cnt3");
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd2, "os_cnt2");
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd1, "os_cnt1");
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd0, "os_cnt0"); exp_now(K_IRQ, 32'h1, "os_irq_set");
    bus(A_CTRL, 1'b0, 0, 1'b0);   exp_rd(32'h4, "os_en_clr"); exp_now(K_IRQ, 32'h1, "os_irq_hold");
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h5, "os_status");
    bus(A_STATUS, 1'b1, 1, 1'b0); exp_rd(32'h5, "os_w1c_pre"); exp_now(K_IRQ, 32'h1, "os_irq_pre");
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h4, "os_cleared"); exp_now(K_IRQ, 32'h0, "os_irq_clr");

    // Auto-reload period 2, irq disabled; W1C on an expiry cycle
    bus(A_LOAD, 1'b1, 32'd2, 1'b0);
    bus(A_CTRL, 1'b1, 32'h3, 1'b0);
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd2, "ar_cnt2a");
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd1, "ar_cnt1a");
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd2, "ar_cnt2b"); exp_now(K_IRQ, 32'h0, "ar_irq_masked");
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd1, "ar_cnt1b");
    bus(A_STATUS, 1'b1, 1, 1'b0); exp_rd(32'h5, "ar_w1c_a");
    bus(A_STATUS, 1'b1, 1, 1'b0); exp_rd(32'h4, "ar_w1c_b");
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h5, "ar_set_wins");
    bus(A_CTRL, 1'b1, 32'h0, 1'b0);
    bus(A_STATUS, 1'b1, 1, 1'b0); exp_rd(32'h5, "ar_stop_exp");
    bus(A_COUNT, 1'b0, 0, 1'b0);  exp_rd(32'd2, "ar_cnt_held");
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h4, "ar_idle_status");

    // Fill FIFO with consumer stalled, then overflow and drain
    push_byte(8'h11, 1'b1, 1'b0); exp_rd(32'h0, "tx_reads0"); exp_now(K_TXV, 32'h0, "tx_empty_v");
    push_byte(8'h12, 1'b1, 1'b0); exp_now(K_TXV, 32'h1, "tx_first_v");
    push_byte(8'h13, 1'b1, 1'b0);
    push_byte(8'h14, 1'b1, 1'b0);
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h42, "tx_full");
    push_byte(8'h15, 1'b0, 1'b0);
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h4A, "tx_ovf");
    repeat (4) bus(32'h0, 1'b0, 0, 1'b1);
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h0C, "tx_drained"); exp_now(K_TXV, 32'h0, "tx_drained_v");
    bus(A_STATUS, 1'b1, 8, 1'b0); exp_rd(32'h0C, "tx_ovf_w1c_pre");
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h04, "tx_ovf_clr");

    // Full FIFO: push and pop in the same cycle
    push_byte(8'h21, 1'b1, 1'b0);
    push_byte(8'h22, 1'b1, 1'b0);
    push_byte(8'h23, 1'b1, 1'b0);
    push_byte(8'h24, 1'b1, 1'b0);
    push_byte(8'h25, 1'b1, 1'b1);
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h42, "pp_full_noovf");
    repeat (4) bus(32'h0, 1'b0, 0, 1'b1);
    bus(A_STATUS, 1'b0, 0, 1'b0); exp_rd(32'h04, "pp_empty"); exp_now(K_TXV, 32'h0, "pp_empty_v");

    // Decode boundaries
    bus(BASE - 32'd4, 1'b1, 32'hFFFF_FFFF, 1'b0); exp_rd(32'h0, "miss_rd"); exp_now(K_HIT, 32'h0, "miss_hit");
    bus(A_LOAD, 1'b0, 0, 1'b0);           exp_rd(32'd2, "miss_load_kept"); exp_now(K_HIT, 32'h1, "load_hit");
    bus(BASE + 32'h02, 1'b1, 32'h7, 1'b0); exp_now(K_HIT, 32'h1, "mis_hit");
    bus(A_CTRL, 1'b0, 0, 1'b0);           exp_rd(32'h0, "mis_ctrl_kept");
    bus(BASE + 32'h09, 1'b0, 0, 1'b0);    exp_rd(32'h0, "mis_count_rd");
    bus(BASE + 32'h14, 1'b0, 0, 1'b0);    exp_rd(32'h0, "unmapped_rd");
    repeat (3) bus(32'h0, 1'b0, 0, 1'b0);
    done = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/mmio_timer_port.md
Name: mmio_timer_port

Overview:
- Memory-mapped I/O responder on the CPU data-memory port: the target end of the memAddr / WriteMem / write-data / read-data interface, in parallel with Memoria.
- Decodes a fixed 32-byte address window and contains:
  - a programmable down-counter timer with a sticky expiry flag and an interrupt output;
  - a byte transmit FIFO drained by an external valid/ready consumer.
- Read timing matches Memoria: address sampled at a clk edge, data valid after that edge.

Parameters:
BASE_ADDR, 32'hFFFF_FF00, window base; must be 32-byte aligned.
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
CNT_W, 32, timer counter width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
addr  in  32  CPU memory address (memAddr)
wr  in  1  write strobe (WriteMem); acts only on a window hit
wdata  in  32  write data (SetSizeMem output)
hit  out  1  combinational: addr[31:5] == BASE_ADDR[31:5]
rdata  out  32  registered read data
tx_valid  out  1  FIFO head valid
tx_data  out  8  FIFO head byte
tx_ready  in  1  consumer accepts head when tx_valid && tx_ready
irq  out  1  expired && CTRL.irq_en

Behaviour:
- One clock (clk). Reset is synchronous and active-high: all state clears at the first clk edge with reset=1.
  - rdata=0, CTRL=0, LOAD=0, COUNT=0, all sticky bits 0, FIFO empty.
  - tx_valid=0, irq=0.
  - Reset mid-transfer discards FIFO contents; a pending write in that cycle is lost.
- Register map (offset = addr[4:0], word aligned):
  - 0x00 CTRL RW: [0] en, [1] auto_reload, [2] irq_en; other bits read 0.
  - 0x04 LOAD RW.
  - 0x08 COUNT RO.
  - 0x0C STATUS:
    - [0] expired, W1C;
    - [1] full, RO;
    - [2] empty, RO;
    - [3] tx_ovf, W1C;
    - [8:4] fifo count, RO.
  - 0x10 TXDATA WO: write pushes wdata[7:0]; reads return 0.
  - Unmapped offsets and addr[1:0]!=0: read 0, writes ignored.
- Read:
  - Each clk edge: rdata <= hit ? reg(addr) : 0.
  - Latency 1 cycle, no wait states.
  - A read in the same cycle as a write returns the pre-write value.
- Timer:
  - While en=1 and COUNT!=0: COUNT decrements by 1 per cycle.
  - On the cycle where COUNT is 1 (transition to 0), expired is set and:
    - auto_reload=1: COUNT <= LOAD;
    - else: en clears and COUNT stays 0.
  - en=1 with COUNT==0 and LOAD==0: no expiry, timer idle.
  - A LOAD write also writes COUNT.
  - CTRL write with en 0->1 and COUNT==0: COUNT <= LOAD.
- Simultaneous events:
  - LOAD write on the expiry cycle: COUNT takes the written value; expired still sets.
  - W1C of expired on the expiry cycle: set wins, expired stays 1.
  - Same rule for tx_ovf.
- FIFO:
  - Push: on a TXDATA write. Pop: when tx_valid && tx_ready.
  - Push when full and no pop: data dropped, tx_ovf set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Empty: no pop; a push becomes visible on tx_valid the next cycle.
  - tx_data is stable while tx_valid=1 && tx_ready=0.
  - Pointers wrap modulo FIFO_DEPTH; count is width log2(DEPTH)+1.
- irq: combinational from registered state; deasserts the cycle after expired is cleared.

Decomposition:
- Package mmio_timer_pkg holds:
  - offset constants OFF_CTRL / LOAD / COUNT / STATUS / TXDATA;
  - CTRL and STATUS bit-index constants.
- Sub-module io_byte_fifo (parameter DEPTH):
  - ports: push, push_data, pop, head, valid, full, empty, count.
- Timer and decode stay in the top module.

Test Plan:
- Reset held 2 cycles, then read 0x0C -> rdata=32'h0000_0004 (empty=1) one cycle after the address; tx_valid=0, irq=0.
- Write LOAD=3, CTRL=3'b101 -> COUNT reads 3,2,1,0 on successive cycles:
  - expired=1 and irq=1 from the cycle COUNT hits 0; en reads 0 afterwards;
  - write STATUS=1 -> irq=0 the next cycle.
- Auto-reload: LOAD=2, CTRL=3'b011 -> expired sets every 2 cycles and COUNT sequence 2,1,2,1 repeats; a W1C on the expiry cycle leaves expired=1.
- tx_ready=0, push bytes 0x11..0x15 (DEPTH=4):
  - full=1 after the 4th push;
  - 5th push dropped and tx_ovf=1, count=4;
  - then tx_ready=1 -> tx_data 0x11,0x12,0x13,0x14 on successive cycles, then empty=1.
- Full FIFO with tx_ready=1 and a push in the same cycle -> count stays 4, tx_ovf stays 0, the new byte appears last.
- addr=BASE_ADDR-4 with wr=1 -> hit=0, no state change, rdata=0; addr=BASE+0x14 read -> 0.
